// File: rtl/decoder_3_8_pkg.sv
// -----------------------------------------------------------------------------
// decoder_3_8_pkg
// Shared types, sizes and the one-hot decode helper for the 3:8 pulse
// sequencer and its optional input FIFO.
// -----------------------------------------------------------------------------
package decoder_3_8_pkg;

    localparam int NUM_LINES = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } dec_state_t;

    // Encoded index -> one-hot line vector (bit i set for index i)
    function automatic logic [NUM_LINES-1:0] decode_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_LINES-1:0] one_v;
        one_v = {{(NUM_LINES-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

endpackage

// File: rtl/decoder_3_8_checker.sv
// -----------------------------------------------------------------------------
// decoder_3_8_checker
// Simulation-time property checks for the pulse sequencer: the encoded index
// must be known whenever it is accepted, and the decoded lines must never
// have more than one bit high.
//
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset (checks disabled while low)
//   accept  in  handshake completes this cycle
//   idx     in  encoded index presented at accept
//   lines   in  registered decoded output
// -----------------------------------------------------------------------------
module decoder_3_8_checker
    import decoder_3_8_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    input logic                 accept,
    input logic [IDX_W-1:0]     idx,
    input logic [NUM_LINES-1:0] lines
);

    a_idx_known: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> !$isunknown(idx));

    a_lines_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(lines));

endmodule

// File: rtl/decoder_3_8_fifo.sv
// -----------------------------------------------------------------------------
// decoder_3_8_fifo
// Two-entry first-in first-out buffer for encoded indices, placed ahead of the
// pulse FSM so the source can hand over the next index while a pulse is still
// in progress. Only built when DECODER_3_8_INPUT_FIFO_EN is defined, so the
// default build carries no unused module.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   flush  in   synchronous clear of all entries
//   push   in   write din (ignored when full)
//   din    in   index to store
//   pop    in   drop the head entry (ignored when empty)
//   dout   out  head entry (valid when !empty)
//   full   out  both entries occupied
//   empty  out  no entries occupied
// -----------------------------------------------------------------------------
`ifdef DECODER_3_8_INPUT_FIFO_EN
module decoder_3_8_fifo
    import decoder_3_8_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_r [0:1];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign push_ok_s = push & (count_r != 2'd2);
    assign pop_ok_s  = pop & (count_r != 2'd0);

    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign dout  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
`endif

// File: rtl/decoder_3_8_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_3_8_pulse_sequencer
// Accepts a 3-bit channel index over a valid/ready handshake and drives the
// matching one-hot strobe line for HOLD_CYCLES clocks, then holds all lines
// low for GAP_CYCLES clocks before the next index may be issued.
//
// Optional feature: define DECODER_3_8_INPUT_FIFO_EN to place a 2-entry input
// FIFO ahead of the FSM. Indices are then accepted during HOLD/GAP, and with
// GAP_CYCLES==0 successive pulses run back to back without an idle cycle.
//
// Parameters:
//   HOLD_CYCLES  cycles each decoded line stays high (1..255)
//   GAP_CYCLES   all-zero cycles after each hold (0..255)
//   CNT_W        width of the shared hold/gap down-counter
//
// Ports:
//   Clock_In           in   system clock, rising edge
//   Reset_N_In         in   asynchronous active-low reset
//   Enable_In          in   block enable; low aborts and flushes
//   Valid_In           in   Encoded_Value_In is valid
//   Encoded_Value_In   in   index 0..7
//   Ready_Out          out  block can accept this cycle
//   Decoded_Value_Out  out  registered one-hot strobe lines
//   Busy_Out           out  FSM not idle (registered)
//   Done_Out           out  pulse on the last hold cycle (registered)
// -----------------------------------------------------------------------------
module decoder_3_8_pulse_sequencer
    import decoder_3_8_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 Clock_In,
    input  logic                 Reset_N_In,
    input  logic                 Enable_In,
    input  logic                 Valid_In,
    input  logic [IDX_W-1:0]     Encoded_Value_In,
    output logic                 Ready_Out,
    output logic [NUM_LINES-1:0] Decoded_Value_Out,
    output logic                 Busy_Out,
    output logic                 Done_Out
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_ZERO;
    localparam logic             HAS_GAP   = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

    dec_state_t           state_r;
    dec_state_t           state_nx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nx_s;
    logic [NUM_LINES-1:0] dout_r;
    logic [NUM_LINES-1:0] dout_nx_s;
    logic                 done_r;
    logic                 done_nx_s;
    logic                 busy_r;
    logic                 busy_nx_s;
    logic                 run_r;
    logic                 ready_s;
    logic                 accept_s;
    logic                 start_s;   // an index is available to start a pulse
    logic                 chain_s;   // a new pulse may follow the hold directly
    logic [IDX_W-1:0]     idx_s;

    assign accept_s = Valid_In & ready_s;

`ifdef DECODER_3_8_INPUT_FIFO_EN
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_pop_s;
    logic [IDX_W-1:0] fifo_idx_s;

    assign ready_s = Enable_In & run_r & ~fifo_full_s;
    assign start_s = ~fifo_empty_s;
    assign chain_s = ~fifo_empty_s & ~HAS_GAP;
    assign idx_s   = fifo_idx_s;

    // Pop exactly when the FSM below loads a new pulse from the head entry
    assign fifo_pop_s = Enable_In & ~fifo_empty_s &
                        ((state_r == ST_IDLE) |
                         ((state_r == ST_HOLD) & (cnt_r == CNT_ZERO) & ~HAS_GAP));

    decoder_3_8_fifo #(
        .W (IDX_W)
    ) u_fifo (
        .clk   (Clock_In),
        .rst_n (Reset_N_In),
        .flush (~Enable_In),
        .push  (accept_s),
        .din   (Encoded_Value_In),
        .pop   (fifo_pop_s),
        .dout  (fifo_idx_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );
`else
    assign ready_s = Enable_In & run_r & (state_r == ST_IDLE);
    assign start_s = accept_s;
    assign chain_s = 1'b0;
    assign idx_s   = Encoded_Value_In;
`endif

    // Next-state, counter and line decode for the IDLE -> HOLD -> GAP sequence
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        dout_nx_s  = dout_r;
        if (!Enable_In) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CNT_ZERO;
            dout_nx_s  = {NUM_LINES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nx_s = ST_HOLD;
                        cnt_nx_s   = HOLD_LOAD;
                        dout_nx_s  = decode_onehot(idx_s);
                    end else begin
                        cnt_nx_s  = CNT_ZERO;
                        dout_nx_s = {NUM_LINES{1'b0}};
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (HAS_GAP) begin
                            state_nx_s = ST_GAP;
                            cnt_nx_s   = GAP_LOAD;
                            dout_nx_s  = {NUM_LINES{1'b0}};
                        end else if (chain_s) begin
                            state_nx_s = ST_HOLD;
                            cnt_nx_s   = HOLD_LOAD;
                            dout_nx_s  = decode_onehot(idx_s);
                        end else begin
                            state_nx_s = ST_IDLE;
                            cnt_nx_s   = CNT_ZERO;
                            dout_nx_s  = {NUM_LINES{1'b0}};
                        end
                    end else begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    dout_nx_s = {NUM_LINES{1'b0}};
                    if (cnt_r == CNT_ZERO) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = CNT_ZERO;
                    dout_nx_s  = {NUM_LINES{1'b0}};
                end
            endcase
        end
    end

    // Done and busy are derived from the next state so they register in
    // step with the line outputs (done marks the hold cycle whose count is 0)
    always_comb begin
        done_nx_s = (state_nx_s == ST_HOLD) && (cnt_nx_s == CNT_ZERO);
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // FSM state and registered outputs
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            dout_r  <= {NUM_LINES{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            dout_r  <= dout_nx_s;
            done_r  <= done_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    // Holds Ready_Out low during reset and for the first edge after release
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    assign Ready_Out         = ready_s;
    assign Decoded_Value_Out = dout_r;
    assign Busy_Out          = busy_r;
    assign Done_Out          = done_r;

    decoder_3_8_checker u_checker (
        .clk    (Clock_In),
        .rst_n  (Reset_N_In),
        .accept (accept_s),
        .idx    (Encoded_Value_In),
        .lines  (dout_r)
    );

endmodule
